mux_scan_sequencer: RTL and testbench



---
 rtl/mux_scan_sequencer.sv | 104 ++++++++++
 tb/tb_mux_scan_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
// Steps an 8:1 single-bit mux through channels 0..7, holds each channel for
// SETTLE+1 cycles, samples the mux output on the last cycle of that window,
// and packs the eight samples into one byte offered over valid/ready.
// Supports single-shot and continuous scans. A frame that finds the output
// slot still occupied is dropped and reported on a sticky overrun flag.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start               begin a scan (only looked at while idle)
//   cont                continuous mode, looked at on each frame-end edge
//   y_in                mux output, already in the clk domain
//   s0, s1, s2          mux selects, channel index = {s0,s1,s2}
//   frame_data          bit k = sample of channel k
//   frame_valid         frame_data holds an unconsumed frame
//   frame_ready         downstream accepts frame_data
//   busy                scan in progress
//   overrun             sticky, a completed frame was dropped
//   clr_ovr             clears overrun (a same-edge drop wins)
module mux_scan_sequencer #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       y_in,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic [7:0] frame_data,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       busy,
    output logic       overrun,
    input  logic       clr_ovr
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t     state;
    logic [2:0] k;
    logic [3:0] cnt;
    logic [6:0] cap;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k           <= 3'd0;
            cnt         <= 4'd0;
            cap         <= 7'd0;
            frame_data  <= 8'h00;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            // Default handshake/clear behaviour; a frame load or a drop
            // further down overrides these on the same edge.
            if (clr_ovr)
                overrun <= 1'b0;
            if (frame_valid && frame_ready)
                frame_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        k     <= 3'd0;
                        cnt   <= 4'd0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (cnt != SETTLE_C) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        cnt <= 4'd0;
                        if (k != 3'd7) begin
                            cap[k] <= y_in;
                            k      <= k + 3'd1;
                        end else begin
                            // Frame end: the last sample goes straight into
                            // the output byte, never through cap.
                            k     <= 3'd0;
                            state <= cont ? SCAN : IDLE;
                            if (!frame_valid || frame_ready) begin
                                frame_data  <= {y_in, cap};
                                frame_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // k returns to 0 at every frame end, so selects read 0 while idle.
    assign {s0, s1, s2} = k;
    assign busy         = (state == SCAN);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (SETTLE=2 and SETTLE=0) share
// the control inputs; each sees its own emulated 8:1 mux. A behavioural
// model (scan time t, channel = t/(SETTLE+1)) predicts every output each
// cycle, and directed scenarios add literal checks that pin the model.
module tb_mux_scan_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, cont, frame_ready, clr_ovr;
    logic [7:0] chans [2];

    logic s0_0, s1_0, s2_0, fv_0, busy_0, ovr_0, y_0;
    logic s0_1, s1_1, s2_1, fv_1, busy_1, ovr_1, y_1;
    logic [7:0] fd_0, fd_1;
    logic [2:0] sel_0, sel_1;

    assign sel_0 = {s0_0, s1_0, s2_0};
    assign sel_1 = {s0_1, s1_1, s2_1};
    assign y_0   = chans[0][sel_0];
    assign y_1   = chans[1][sel_1];

    mux_scan_sequencer #(.SETTLE(2)) u0 (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .y_in(y_0),
        .s0(s0_0), .s1(s1_0), .s2(s2_0), .frame_data(fd_0),
        .frame_valid(fv_0), .frame_ready(frame_ready), .busy(busy_0),
        .overrun(ovr_0), .clr_ovr(clr_ovr));

    mux_scan_sequencer #(.SETTLE(0)) u1 (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .y_in(y_1),
        .s0(s0_1), .s1(s1_1), .s2(s2_1), .frame_data(fd_1),
        .frame_valid(fv_1), .frame_ready(frame_ready), .busy(busy_1),
        .overrun(ovr_1), .clr_ovr(clr_ovr));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int settle_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    // ---------------- behavioural model ----------------
    bit         m_scan [2];
    int         m_t    [2];   // cycles spent in the current frame
    logic [7:0] m_frame[2];
    logic [7:0] m_fd   [2];
    bit         m_fv   [2];
    bit         m_ovr  [2];
    bit         checking = 1'b0;
    int         ml, mk;
    bit         fe, xfer;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            ml = settle_of(i) + 1;
            if (rst) begin
                m_scan[i] = 0; m_t[i] = 0; m_fd[i] = 8'h00;
                m_fv[i] = 0; m_ovr[i] = 0; m_frame[i] = 8'h00;
            end else begin
                fe   = 0;
                xfer = m_fv[i] && frame_ready;
                if (m_scan[i]) begin
                    mk = m_t[i] / ml;
                    if (m_t[i] % ml == ml - 1) begin
                        m_frame[i][mk] = chans[i][mk];
                        if (mk == 7) fe = 1;
                    end
                    m_t[i]++;
                    if (fe) begin
                        m_t[i]    = 0;
                        m_scan[i] = cont;
                    end
                end else if (start) begin
                    m_scan[i] = 1;
                    m_t[i]    = 0;
                end
                if (clr_ovr) m_ovr[i] = 0;
                if (fe) begin
                    if (!m_fv[i] || frame_ready) begin
                        m_fd[i] = m_frame[i];
                        m_fv[i] = 1;
                    end else begin
                        m_ovr[i] = 1;
                    end
                end else if (xfer) begin
                    m_fv[i] = 0;
                end
            end
        end
        if (rst) checking = 1'b1;
    end

    function automatic logic [7:0] m_sel(input int i);
        return m_scan[i] ? 8'(m_t[i] / (settle_of(i) + 1)) : 8'd0;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (checking) begin
            chk("sel0",  8'(sel_0),  m_sel(0));
            chk("fd0",   fd_0,       m_fd[0]);
            chk("fv0",   8'(fv_0),   8'(m_fv[0]));
            chk("busy0", 8'(busy_0), 8'(m_scan[0]));
            chk("ovr0",  8'(ovr_0),  8'(m_ovr[0]));
            chk("sel1",  8'(sel_1),  m_sel(1));
            chk("fd1",   fd_1,       m_fd[1]);
            chk("fv1",   8'(fv_1),   8'(m_fv[1]));
            chk("busy1", 8'(busy_1), 8'(m_scan[1]));
            chk("ovr1",  8'(ovr_1),  8'(m_ovr[1]));
        end
    end

    // start pulse across edge 0; returns just after edge 0
    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1; start = 0; cont = 0; frame_ready = 0; clr_ovr = 0;
        chans[0] = 8'h00; chans[1] = 8'h00;

        // reset and idle
        repeat (3) @(negedge clk);
        chk("rst_fd0", fd_0, 8'h00);
        chk("rst_fv0", 8'(fv_0), 8'd0);
        chk("rst_sel1", 8'(sel_1), 8'd0);
        rst = 0;
        repeat (50) @(negedge clk);

        // single shot, SETTLE=2, a..h = 1,0,1,0,0,1,0,1
        chans[0] = 8'hA5; chans[1] = 8'hA5; frame_ready = 1;
        pulse_start();
        repeat (23) @(negedge clk);
        chk("ss_fv_before", 8'(fv_0), 8'd0);
        chk("ss_busy_before", 8'(busy_0), 8'd1);
        @(negedge clk);
        chk("ss_fv_edge24", 8'(fv_0), 8'd1);
        chk("ss_fd", fd_0, 8'hA5);
        chk("ss_busy_after", 8'(busy_0), 8'd0);
        @(negedge clk);
        chk("ss_fv_one_cycle", 8'(fv_0), 8'd0);
        repeat (5) @(negedge clk);

        // continuous, SETTLE=0, ready held high
        chans[1] = 8'h3C; cont = 1;
        pulse_start();
        repeat (8) @(negedge clk);
        chk("cont_fv1", 8'(fv_1), 8'd1);
        chk("cont_fd1", fd_1, 8'h3C);
        chans[1] = 8'hC3;
        repeat (8) @(negedge clk);
        chk("cont_fv2", 8'(fv_1), 8'd1);
        chk("cont_fd2", fd_1, 8'hC3);
        chk("cont_ovr", 8'(ovr_1), 8'd0);
        cont = 0;
        repeat (40) @(negedge clk);

        // backpressure, SETTLE=0
        frame_ready = 0; chans[1] = 8'h5A; cont = 1;
        pulse_start();
        repeat (8) @(negedge clk);
        chk("bp_fd1", fd_1, 8'h5A);
        chans[1] = 8'h81;
        repeat (8) @(negedge clk);
        chk("bp_ovr", 8'(ovr_1), 8'd1);
        chk("bp_fd_hold", fd_1, 8'h5A);
        cont = 0;
        repeat (10) @(negedge clk);
        clr_ovr = 1;
        @(negedge clk); clr_ovr = 0;
        chk("bp_clr", 8'(ovr_1), 8'd0);
        frame_ready = 1;
        repeat (40) @(negedge clk);

        // same-edge load and consume
        frame_ready = 0; chans[1] = 8'h11; cont = 1;
        pulse_start();
        repeat (8) @(negedge clk);
        chk("se_fd1", fd_1, 8'h11);
        chans[1] = 8'h22;
        repeat (7) @(negedge clk);
        frame_ready = 1;
        @(negedge clk);
        chk("se_fv", 8'(fv_1), 8'd1);
        chk("se_fd2", fd_1, 8'h22);
        chk("se_ovr", 8'(ovr_1), 8'd0);
        cont = 0;
        repeat (40) @(negedge clk);

        // reset mid-scan at k=4 (SETTLE=2)
        chans[0] = 8'h96;
        pulse_start();
        repeat (12) @(negedge clk);
        chk("rm_k4", 8'(sel_0), 8'd4);
        rst = 1;
        @(negedge clk);
        chk("rm_busy", 8'(busy_0), 8'd0);
        chk("rm_sel", 8'(sel_0), 8'd0);
        chk("rm_fv", 8'(fv_0), 8'd0);
        rst = 0;
        pulse_start();
        repeat (23) @(negedge clk);
        chk("rm_fv_before", 8'(fv_0), 8'd0);
        @(negedge clk);
        chk("rm_fv", 8'(fv_0), 8'd1);
        chk("rm_fd", fd_0, 8'h96);
        repeat (5) @(negedge clk);

        // randomized traffic
        repeat (600) begin
            @(negedge clk);
            start       = ($urandom_range(0, 3) == 0);
            cont        = ($urandom_range(0, 1) == 1);
            frame_ready = ($urandom_range(0, 3) != 0);
            clr_ovr     = ($urandom_range(0, 7) == 0);
            rst         = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 5) == 0) chans[0] = 8'($urandom);
            if ($urandom_range(0, 5) == 0) chans[1] = 8'($urandom);
        end
        @(negedge clk);
        rst = 0; start = 0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
